cam_rgb444_capture: RTL and testbench
=====================================

# cam_rgb444_capture

Synthesizable receiver for the OV7670-style camera port (pclk, vsync, href, 8-bit data) in RGB444 two-bytes-per-pixel mode. Assembles byte pairs into 12-bit pixels and issues single-cycle writes to the frame-buffer port of the dual-port RAM, 160x120 pixels, linear row-major addressing. Sits between the camera pins and the DP_RAM write port; the VGA driver reads the other RAM port. Also reports frame completion, a frame counter and a sticky framing-error flag.

## Interface
- H_PIX, 160: pixels per line (bytes per line = 2*H_PIX)
- V_LINES, 120: lines per frame
- AW, 15: RAM address width; H_PIX*V_LINES must be <= 2^AW
- pclk  in  1  camera pixel clock; the only clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- vsync  in  1  frame sync; high = vertical blanking
- href  in  1  line valid; high while line bytes are on px_data
- px_data  in  8  camera byte; changes on pclk falling edge
- capture_en  in  1  arm capture of the next frame
- mem_we  out  1  RAM write strobe, one cycle per pixel
- mem_addr  out  AW  RAM write address (pixel index)
- mem_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- busy  out  1  high while a frame is being captured
- frame_done  out  1  one-cycle pulse at end of a captured frame
- frame_cnt  out  8  captured-frame counter, wraps 255->0
- frame_err  out  1  sticky error for the current/last captured frame

## Operation
- Registered vsync_q, href_q on pclk; reset values vsync_q=0, href_q=0.
- SOF = vsync_q & ~vsync; EOF = ~vsync_q & vsync; EOL = href_q & ~href.
- States: IDLE, ACTIVE.
- IDLE: on SOF with capture_en=1 -> ACTIVE; clear pixel address, line counter, byte phase, frame_err. SOF with capture_en=0: stay IDLE. Reset mid-frame: vsync_q=0 means capture waits for the next full frame.
- ACTIVE, href=1, each rising edge: phase 0 latches R=px_data[3:0] (px_data[7:4] ignored); phase 1 forms pixel {R, px_data[7:0]}, requests a write, increments the pixel address and the per-line pixel counter. Phase toggles per byte.
- Write suppressed (mem_we stays 0) and frame_err set if pixel address already equals H_PIX*V_LINES (overflow); address saturates, no wrap.
- EOL: if per-line byte count != 2*H_PIX, set frame_err (an odd trailing byte is discarded). Reset phase and per-line counter; increment line counter.
- EOF in ACTIVE: if line counter != V_LINES, set frame_err; pulse frame_done; frame_cnt+1; -> IDLE. EOF coincident with href=1: partial line discarded, frame_err set, then normal EOF handling.
- capture_en is sampled only in IDLE; deasserting it in ACTIVE does not abort the frame.
- busy = (state==ACTIVE).
- frame_err holds until the next armed SOF.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_data=0, busy=0, frame_done=0, frame_cnt=0, frame_err=0, state IDLE.
- Second byte sampled at edge N -> mem_we=1 with mem_addr/mem_data valid for the cycle after edge N (1-cycle latency), all registered.
- mem_addr holds the written pixel index k = line*H_PIX + column, 0..19199 with defaults.
- busy rises the cycle after the SOF edge; frame_done is asserted the cycle after the EOF edge, together with busy=0 and the incremented frame_cnt.
- Back-to-back frames: SOF for frame n+1 is accepted on any edge after returning to IDLE; no dead cycles are required.
- Maximum write rate: one write every 2 pclk.

## Test plan
- Nominal frame (vsync high 2 rows, 4 blank rows, 120 lines x 320 bytes, bytes 0x0F,0x00 repeating, capture_en=1) -> 19200 writes, addr 0..19199 in order, every mem_data=0xF00, frame_done one pulse, frame_cnt=1, frame_err=0.
- Alternating pairs 0x00,0x0F / 0x00,0xF0 per pixel -> mem_data alternates 0x00F, 0x0F0; line 1 first write at addr 160.
- One line of 319 bytes -> that line writes 159 pixels, next line starts at its correct index (line*160 minus 1, since no padding), frame_err=1 at frame_done.
- capture_en=0 for the first frame, then 1 -> no writes, no frame_done during frame 1; frame 2 fully captured, frame_cnt=1.
- rst asserted mid-frame at line 50 and released -> all outputs 0 immediately; no writes until next SOF; the following frame captured starting at addr 0.
- 121 lines of data -> writes stop at addr 19199 (no wrap to 0), frame_err=1, frame_done pulses once.

Source files
------------

// File: rtl/cam_rgb444_capture.sv
// rtl/cam_rgb444_capture.sv - OV7670-style RGB444 camera receiver writing 12-bit pixels to a frame buffer
module cam_rgb444_capture #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int AW      = 15
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic          capture_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [11:0]   mem_data,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          frame_err
);

  localparam int BW = $clog2(2*H_PIX + 1) + 1;
  localparam int LW = $clog2(V_LINES + 1) + 1;
  localparam int TOTAL = H_PIX * V_LINES;
  localparam logic [AW:0]   PIX_MAX    = TOTAL[AW:0];
  localparam logic [BW-1:0] LINE_BYTES = BW'(2*H_PIX);
  localparam logic [LW-1:0] FRAME_LINES = LW'(V_LINES);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic          vsync_q, href_q;
  logic          phase;
  logic [3:0]    red;
  logic [AW:0]   pix_addr;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic [LW-1:0] line_total;
  logic          sof, eof, eol;

  assign sof  = vsync_q & ~vsync;
  assign eof  = ~vsync_q & vsync;
  assign eol  = href_q & ~href;
  assign busy = (state_q == ACTIVE);

  // A line ending on the same edge as vsync still counts toward the frame.
  assign line_total = eol ? line_cnt + LW'(1) : line_cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sof && capture_en) state_d = ACTIVE;
      ACTIVE:  if (eof) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      phase      <= 1'b0;
      red        <= '0;
      pix_addr   <= '0;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      href_q     <= href;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      if (state_q == IDLE) begin
        if (sof && capture_en) begin
          pix_addr  <= '0;
          line_cnt  <= '0;
          byte_cnt  <= '0;
          phase     <= 1'b0;
          frame_err <= 1'b0;
        end
      end else if (eof) begin
        // Bytes on the closing edge belong to a truncated line and are dropped.
        if (href || (line_total != FRAME_LINES) || (eol && byte_cnt != LINE_BYTES))
          frame_err <= 1'b1;
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
      end else if (href) begin
        if (byte_cnt != '1) byte_cnt <= byte_cnt + BW'(1);
        phase <= ~phase;
        if (!phase) begin
          red <= px_data[3:0];
        end else if (pix_addr == PIX_MAX) begin
          frame_err <= 1'b1;
        end else begin
          mem_we   <= 1'b1;
          mem_addr <= pix_addr[AW-1:0];
          mem_data <= {red, px_data};
          pix_addr <= pix_addr + (AW+1)'(1);
        end
      end else if (eol) begin
        if (byte_cnt != LINE_BYTES) frame_err <= 1'b1;
        phase    <= 1'b0;
        byte_cnt <= '0;
        if (line_cnt != '1) line_cnt <= line_cnt + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cam_rgb444_capture.sv
// tb/tb_cam_rgb444_capture.sv - directed bench for cam_rgb444_capture on a reduced 4x3 frame
module tb_cam_rgb444_capture;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic [7:0]    px_data = 8'h00;
  logic          capture_en = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_data;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          frame_err;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t  wq[$];
  int   done_cnt;
  logic err_at_done, busy_at_done;
  int   vectors = 0;
  int   miscompares = 0;

  cam_rgb444_capture #(.H_PIX(H), .V_LINES(V), .AW(AW)) dut (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
    .capture_en(capture_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (mem_we) wq.push_back('{addr: int'(mem_addr), data: int'(mem_data)});
    if (frame_done) begin
      done_cnt++;
      err_at_done  = frame_err;
      busy_at_done = busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    done_cnt = 0;
    err_at_done = 1'b0;
    busy_at_done = 1'b1;
  endtask

  task automatic frame_start(input logic expect_busy);
    vsync = 1'b1;
    href = 1'b0;
    repeat (2) @(negedge pclk);
    vsync = 1'b0;
    @(negedge pclk);
    check("busy_after_sof", 32'(busy), 32'(expect_busy));
    @(negedge pclk);
  endtask

  // mode 0: 0x0F,0x00 -> 0xF00; mode 1: 0x00,0x0F / 0x00,0xF0 -> 0x00F / 0x0F0
  task automatic send_line(input int nbytes, input int mode);
    for (int b = 0; b < nbytes; b++) begin
      @(negedge pclk);
      href = 1'b1;
      if (mode == 0) px_data = (b % 2 == 0) ? 8'h0F : 8'h00;
      else if (b % 2 == 0) px_data = 8'h00;
      else px_data = ((b / 2) % 2 == 0) ? 8'h0F : 8'hF0;
    end
    @(negedge pclk);
    href = 1'b0;
    @(negedge pclk);
  endtask

  task automatic frame_end();
    @(negedge pclk);
    vsync = 1'b1;
    repeat (3) @(negedge pclk);
  endtask

  task automatic check_writes(input int n, input int mode);
    check("write_count", 32'(wq.size()), 32'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      check("wr_addr", 32'(wq[k].addr), 32'(k));
      if (mode == 0) check("wr_data", 32'(wq[k].data), 32'h0F00);
      else check("wr_data", 32'(wq[k].data), (k % 2 == 0) ? 32'h000F : 32'h00F0);
    end
  endtask

  initial begin
    clear_mon();
    repeat (2) @(negedge pclk);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge pclk);

    // nominal frame
    clear_mon();
    frame_start(1'b1);
    repeat (V) send_line(2*H, 0);
    frame_end();
    check_writes(12, 0);
    check("nom_done", 32'(done_cnt), 1);
    check("nom_cnt", 32'(frame_cnt), 1);
    check("nom_err", 32'(err_at_done), 0);
    check("nom_busy_at_done", 32'(busy_at_done), 0);

    // alternating pixel colours
    clear_mon();
    frame_start(1'b1);
    repeat (V) send_line(2*H, 1);
    frame_end();
    check_writes(12, 1);
    check("alt_line1_addr", 32'(wq.size() > 4 ? wq[4].addr : -1), 32'(H));
    check("alt_cnt", 32'(frame_cnt), 2);
    check("alt_err", 32'(err_at_done), 0);

    // short line: odd trailing byte dropped, no padding
    clear_mon();
    frame_start(1'b1);
    send_line(2*H, 0);
    send_line(2*H - 1, 0);
    send_line(2*H, 0);
    frame_end();
    check_writes(11, 0);
    check("short_line2_addr", 32'(wq.size() > 7 ? wq[7].addr : -1), 32'(2*H - 1));
    check("short_err", 32'(err_at_done), 1);
    check("short_done", 32'(done_cnt), 1);

    // unarmed frame ignored, next armed frame captured
    clear_mon();
    capture_en = 1'b0;
    frame_start(1'b0);
    repeat (V) send_line(2*H, 0);
    frame_end();
    check("unarmed_writes", 32'(wq.size()), 0);
    check("unarmed_done", 32'(done_cnt), 0);
    check("unarmed_cnt", 32'(frame_cnt), 3);
    capture_en = 1'b1;
    frame_start(1'b1);
    repeat (V) send_line(2*H, 0);
    frame_end();
    check_writes(12, 0);
    check("armed_cnt", 32'(frame_cnt), 4);
    check("armed_err", 32'(err_at_done), 0);

    // reset in the middle of a frame
    clear_mon();
    frame_start(1'b1);
    send_line(2*H, 0);
    @(negedge pclk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cnt", 32'(frame_cnt), 0);
    check("midrst_addr", 32'(mem_addr), 0);
    check("midrst_data", 32'(mem_data), 0);
    check("midrst_we", 32'(mem_we), 0);
    @(negedge pclk);
    rst = 1'b0;
    clear_mon();
    repeat (V - 1) send_line(2*H, 0);
    frame_end();
    check("midrst_writes", 32'(wq.size()), 0);
    check("midrst_done", 32'(done_cnt), 0);
    frame_start(1'b1);
    repeat (V) send_line(2*H, 0);
    frame_end();
    check_writes(12, 0);
    check("after_rst_cnt", 32'(frame_cnt), 1);

    // one line too many: address saturates, no wrap
    clear_mon();
    frame_start(1'b1);
    repeat (V + 1) send_line(2*H, 0);
    frame_end();
    check_writes(12, 0);
    check("ovf_err", 32'(err_at_done), 1);
    check("ovf_done", 32'(done_cnt), 1);
    check("ovf_cnt", 32'(frame_cnt), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
